ddr3_ca_delay_line_ctrl: RTL and testbench
==========================================

# ddr3_ca_delay_line_ctrl

Sequencer for the dynamic output delay lines of the DDR3 command/address IOD lanes (WE_N, RAS_N, CAS_N, address, bank). It accepts one tap-adjust request at a time from the training/calibration logic. It drives the per-lane DELAY_LINE_LOAD/MOVE/DIRECTION strobes with the required settle spacing, keeps a shadow tap count per lane, and reports the result. It sits in the FAB_CLK domain between the calibration engine and the IOD instances.

## Interface
Parameters:
- NUM_LANES, 8, number of controlled IOD lanes (1..32)
- TAP_W, 7, tap counter width
- MAX_TAPS, 127, highest legal tap value (≤ 2^TAP_W−1)
- SETTLE_CYCLES, 4, idle cycles after every LOAD/MOVE pulse (≥1)

Ports:
- FAB_CLK  in  1  fabric clock; all logic rising-edge
- ARST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request strobe
- REQ_READY  out  1  high only in IDLE
- REQ_LANE  in  $clog2(NUM_LANES) (min 1)  target lane
- REQ_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 READ
- REQ_COUNT  in  TAP_W  tap steps for INC/DEC
- RSP_VALID  out  1  one-cycle result pulse, no backpressure
- RSP_TAP  out  TAP_W  shadow tap of lane after operation
- RSP_ERR  out  1  qualified by RSP_VALID
- BUSY  out  1  = !REQ_READY
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load strobe
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move strobe
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = increment
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag

## Operation
- FSM states: IDLE, PREP, LOAD, MOVE, SETTLE, RESP.
- Accept when REQ_VALID && REQ_READY. Latch lane, op, count.
- Immediate checks at accept go straight to RESP with no strobes:
  - lane ≥ NUM_LANES: err=1, RSP_TAP=0
  - READ: err=0
  - INC/DEC with count 0: err=0
  - INC with tap+count > MAX_TAPS: err=1, tap unchanged
  - DEC with count > tap: err=1, tap unchanged
- LOAD sequence: LOAD (strobe 1 cycle) → SETTLE ×SETTLE_CYCLES → RESP. Shadow tap becomes 0. err = OUT_OF_RANGE[lane] sampled in the last SETTLE cycle.
- INC/DEC sequence: PREP (drive DIRECTION[lane]) → repeat {MOVE (strobe 1 cycle, tap ±1), SETTLE ×SETTLE_CYCLES} count times → RESP.
- OUT_OF_RANGE[lane] is sampled in the last SETTLE cycle of each step. If it is 1, remaining steps are abandoned and the FSM goes to RESP with err=1. The tap keeps the steps already taken, including the failing step.
- Only the bits of the addressed lane ever assert. LOAD and MOVE are never high in the same cycle. At most one strobe is asserted at any time.
- DIRECTION[lane] holds its value from PREP until the next PREP for that lane. DIRECTION bits of other lanes hold their values.
- Shadow tap arithmetic is unsigned TAP_W. Wrap is impossible because of the pre-checks.
- Reset (async, any state): FSM→IDLE; all shadow taps, LOAD, MOVE, DIRECTION, RSP_VALID, RSP_TAP and RSP_ERR are 0; REQ_READY=1, BUSY=0. An operation interrupted by reset is lost. Calibration must issue LOAD per lane after reset.

## Timing
- The accept edge is cycle 0. All outputs are registered.
- Immediate/READ: RSP_VALID at cycle 1.
- LOAD: LOAD strobe at cycle 1, SETTLE at cycles 2..S+1, RSP_VALID at cycle S+2.
- INC/DEC of N steps with S=SETTLE_CYCLES:
  - PREP at cycle 1
  - MOVE k (k=0..N−1) at cycle 2+k(1+S)
  - RSP_VALID at cycle N(1+S)+2
- REQ_READY returns high the cycle after RSP_VALID. Back-to-back requests are therefore accepted every latency+1 cycles.
- OUT_OF_RANGE abort at step k: RSP_VALID at cycle 2+(k+1)(1+S).

## Test plan
- Reset then READ lane 3 → RSP_VALID at cycle 1, RSP_TAP=0, err=0, no strobes.
- LOAD lane 0, INC lane 0 count 3, S=4:
  - LOAD strobe at cycle 1
  - after the INC accept, DIRECTION[0]=1 from cycle 1; MOVE[0] at cycles 2, 7, 12; RSP_VALID at cycle 17 with RSP_TAP=3, err=0
- Lane 5 at tap 2: DEC count 3 → err=1, tap 2, no MOVE. INC count 126 → err=1. INC count 125 → tap 127, err=0.
- INC lane 1 count 10 with OUT_OF_RANGE[1] forced high before the step-2 sample → exactly 3 MOVE pulses, RSP_TAP=3, err=1.
- Assert ARST_N low during the MOVE sequence → all strobes 0 within the reset cycle, REQ_READY=1, READ returns tap 0. Lane ≥ NUM_LANES request → err=1, no strobes.

Source files
------------

// File: rtl/ddr3_ca_delay_line_ctrl_if.sv
// Request/response bundle between the calibration engine
// and the DDR3 CA delay-line sequencer.
interface ddr3_ca_delay_line_ctrl_if #(
   parameter int NUM_LANES = 8,
   parameter int TAP_W     = 7
);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic             REQ_VALID;
   logic             REQ_READY;
   logic [LW-1:0]    REQ_LANE;
   logic [1:0]       REQ_OP;
   logic [TAP_W-1:0] REQ_COUNT;
   logic             RSP_VALID;
   logic [TAP_W-1:0] RSP_TAP;
   logic             RSP_ERR;
   logic             BUSY;

   modport master (
      output REQ_VALID, REQ_LANE, REQ_OP, REQ_COUNT,
      input  REQ_READY, RSP_VALID, RSP_TAP, RSP_ERR, BUSY
   );

   modport slave (
      input  REQ_VALID, REQ_LANE, REQ_OP, REQ_COUNT,
      output REQ_READY, RSP_VALID, RSP_TAP, RSP_ERR, BUSY
   );
endinterface

// File: rtl/ddr3_ca_delay_line_ctrl.sv
// Sequences LOAD/MOVE/DIRECTION strobes for the DDR3 CA IOD
// delay lines and tracks a shadow tap count per lane.
module ddr3_ca_delay_line_ctrl #(
   parameter int NUM_LANES     = 8,
   parameter int TAP_W         = 7,
   parameter int MAX_TAPS      = 127,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                     FAB_CLK,
   input  logic                     ARST_N,
   ddr3_ca_delay_line_ctrl_if.slave bus,
   output logic [NUM_LANES-1:0]     DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0]     DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]     DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0]     DELAY_LINE_OUT_OF_RANGE
);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_LOAD,
      S_MOVE,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [LW-1:0]        r_lane;
   logic                 r_is_load;
   logic                 r_inc;
   logic [TAP_W-1:0]     r_left;
   logic [CW-1:0]        r_cnt;
   logic [TAP_W-1:0]     r_tap [NUM_LANES];
   logic [NUM_LANES-1:0] r_load;
   logic [NUM_LANES-1:0] r_move;
   logic [NUM_LANES-1:0] r_dir;
   logic                 r_rsp_valid;
   logic [TAP_W-1:0]     r_rsp_tap;
   logic                 r_rsp_err;
   logic                 r_ready;
   logic                 r_busy;

   logic                 w_accept;
   logic                 w_lane_ok;
   logic [TAP_W-1:0]     w_req_tap;
   logic [TAP_W-1:0]     w_cur_tap;
   logic                 w_oor;
   logic [TAP_W:0]       w_sum;
   logic                 w_last;
   logic [LW-1:0]        w_sel;
   logic [NUM_LANES-1:0] w_sel_oh;
   logic [TAP_W-1:0]     w_rsp_tap;
   logic                 w_rsp_err;

   assign w_lane_ok = int'(bus.REQ_LANE) < NUM_LANES;
   assign w_last    = r_cnt == CW'(SETTLE_CYCLES - 1);
   assign w_sum     = {1'b0, w_req_tap} + {1'b0, bus.REQ_COUNT};
   assign w_sel     = (r_state == S_IDLE) ? bus.REQ_LANE : r_lane;

   always_comb begin
      w_req_tap = '0;
      w_cur_tap = '0;
      w_oor     = 1'b0;
      w_sel_oh  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (bus.REQ_LANE == LW'(i)) w_req_tap = r_tap[i];
         if (r_lane == LW'(i)) begin
            w_cur_tap = r_tap[i];
            w_oor     = DELAY_LINE_OUT_OF_RANGE[i];
         end
         w_sel_oh[i] = (w_sel == LW'(i));
      end
   end

   // Rejected or trivial requests respond next cycle without touching the IOD.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_rsp_tap = r_rsp_tap;
      w_rsp_err = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.REQ_VALID) begin
               w_accept  = 1'b1;
               w_rsp_tap = w_req_tap;
               if (!w_lane_ok) begin
                  w_next    = S_RESP;
                  w_rsp_err = 1'b1;
                  w_rsp_tap = '0;
               end else if (bus.REQ_OP == OP_READ ||
                            (bus.REQ_OP != OP_LOAD && bus.REQ_COUNT == '0)) begin
                  w_next = S_RESP;
               end else if (bus.REQ_OP == OP_INC &&
                            w_sum > (TAP_W+1)'(MAX_TAPS)) begin
                  w_next    = S_RESP;
                  w_rsp_err = 1'b1;
               end else if (bus.REQ_OP == OP_DEC &&
                            bus.REQ_COUNT > w_req_tap) begin
                  w_next    = S_RESP;
                  w_rsp_err = 1'b1;
               end else if (bus.REQ_OP == OP_LOAD) begin
                  w_next = S_LOAD;
               end else begin
                  w_next = S_PREP;
               end
            end
         end
         S_PREP:   w_next = S_MOVE;
         S_LOAD:   w_next = S_SETTLE;
         S_MOVE:   w_next = S_SETTLE;
         S_SETTLE: begin
            if (w_last) begin
               if (w_oor || r_is_load || r_left == '0) begin
                  w_next    = S_RESP;
                  w_rsp_err = w_oor;
                  w_rsp_tap = w_cur_tap;
               end else begin
                  w_next = S_MOVE;
               end
            end
         end
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_state     <= S_IDLE;
         r_lane      <= '0;
         r_is_load   <= 1'b0;
         r_inc       <= 1'b0;
         r_left      <= '0;
         r_cnt       <= '0;
         r_load      <= '0;
         r_move      <= '0;
         r_dir       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_tap   <= '0;
         r_rsp_err   <= 1'b0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= '0;
      end else begin
         r_state     <= w_next;
         r_ready     <= (w_next == S_IDLE);
         r_busy      <= (w_next != S_IDLE);
         r_rsp_valid <= (w_next == S_RESP);
         r_load      <= (w_next == S_LOAD) ? w_sel_oh : '0;
         r_move      <= (w_next == S_MOVE) ? w_sel_oh : '0;
         r_cnt       <= (r_state == S_SETTLE) ? r_cnt + CW'(1) : '0;
         if (w_next == S_RESP) begin
            r_rsp_tap <= w_rsp_tap;
            r_rsp_err <= w_rsp_err;
         end
         if (w_accept) begin
            r_lane    <= bus.REQ_LANE;
            r_is_load <= (bus.REQ_OP == OP_LOAD);
            r_inc     <= (bus.REQ_OP == OP_INC);
            r_left    <= bus.REQ_COUNT;
         end
         if (w_next == S_PREP) begin
            r_dir <= (bus.REQ_OP == OP_INC) ? (r_dir | w_sel_oh)
                                            : (r_dir & ~w_sel_oh);
         end
         if (r_state == S_MOVE) r_left <= r_left - TAP_W'(1);
         // Shadow tap follows the strobe that was just issued.
         for (int i = 0; i < NUM_LANES; i++) begin
            if (r_lane == LW'(i)) begin
               if (r_state == S_LOAD)
                  r_tap[i] <= '0;
               else if (r_state == S_MOVE)
                  r_tap[i] <= r_inc ? r_tap[i] + TAP_W'(1)
                                    : r_tap[i] - TAP_W'(1);
            end
         end
      end
   end

   assign bus.REQ_READY        = r_ready;
   assign bus.BUSY             = r_busy;
   assign bus.RSP_VALID        = r_rsp_valid;
   assign bus.RSP_TAP          = r_rsp_tap;
   assign bus.RSP_ERR          = r_rsp_err;
   assign DELAY_LINE_LOAD      = r_load;
   assign DELAY_LINE_MOVE      = r_move;
   assign DELAY_LINE_DIRECTION = r_dir;
endmodule

// File: tb/tb_ddr3_ca_delay_line_ctrl.sv
// Bench for ddr3_ca_delay_line_ctrl: directed vector table,
// reset-during-move sequence and randomized requests vs a model.
module tb_ddr3_ca_delay_line_ctrl;
   localparam int NL = 6;
   localparam int TW = 7;
   localparam int MT = 127;
   localparam int S  = 4;
   localparam int OP_LOAD = 0;
   localparam int OP_INC  = 1;
   localparam int OP_DEC  = 2;
   localparam int OP_READ = 3;

   logic          FAB_CLK = 1'b0;
   logic          ARST_N  = 1'b0;
   logic [NL-1:0] dl_load;
   logic [NL-1:0] dl_move;
   logic [NL-1:0] dl_dir;
   logic [NL-1:0] dl_oor = '0;

   ddr3_ca_delay_line_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

   ddr3_ca_delay_line_ctrl #(
      .NUM_LANES(NL), .TAP_W(TW), .MAX_TAPS(MT), .SETTLE_CYCLES(S)
   ) dut (
      .FAB_CLK                 (FAB_CLK),
      .ARST_N                  (ARST_N),
      .bus                     (bus),
      .DELAY_LINE_LOAD         (dl_load),
      .DELAY_LINE_MOVE         (dl_move),
      .DELAY_LINE_DIRECTION    (dl_dir),
      .DELAY_LINE_OUT_OF_RANGE (dl_oor)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   typedef struct {
      int tap; int err; int lat; int moves; int loads; int bad;
   } res_t;

   typedef struct {
      int lane; int op; int cnt; int oor_k;
      int tap; int err; int lat; int moves; int loads;
   } vec_t;

   int            tests = 0;
   int            fails = 0;
   int            m_tap [NL];
   logic [NL-1:0] m_dir = '0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: outcome of a request from the operation rules alone.
   task automatic model(input int lane, input int op, input int cnt,
                        input int oor_k, output res_t e);
      int steps;
      bit abort;
      e = '{default: 0};
      e.lat = 1;
      if (lane >= NL) begin
         e.err = 1;
         return;
      end
      e.tap = m_tap[lane];
      if (op == OP_READ || (op != OP_LOAD && cnt == 0)) return;
      if (op == OP_INC && m_tap[lane] + cnt > MT) begin e.err = 1; return; end
      if (op == OP_DEC && cnt > m_tap[lane]) begin e.err = 1; return; end
      if (op == OP_LOAD) begin
         m_tap[lane] = 0;
         e.tap   = 0;
         e.loads = 1;
         e.err   = (oor_k >= 0) ? 1 : 0;
         e.lat   = S + 2;
         return;
      end
      abort = (oor_k >= 0 && oor_k < cnt);
      steps = abort ? oor_k + 1 : cnt;
      m_tap[lane] += (op == OP_INC) ? steps : -steps;
      m_dir[lane] = (op == OP_INC);
      e.err   = abort ? 1 : 0;
      e.tap   = m_tap[lane];
      e.moves = steps;
      e.lat   = steps * (1 + S) + 2;
   endtask

   task automatic drive_oor(input int lane, input bit hi);
      dl_oor = NL'($urandom);
      if (lane < NL) dl_oor[lane] = hi;
   endtask

   task automatic run(input int lane, input int op, input int cnt,
                      input int oor_k, output res_t o);
      int            c;
      bit            hi;
      bit            done;
      logic [NL-1:0] lm;
      logic [NL-1:0] sb;
      o = '{default: 0};
      o.lat = -1;
      lm = (lane < NL) ? (NL'(1) << lane) : '0;
      hi = 1'b0;
      c = 0;
      while (!bus.REQ_READY && c < 1000) begin
         @(posedge FAB_CLK); #1; c++;
      end
      if (!bus.REQ_READY) begin
         o.bad++;
         return;
      end
      bus.REQ_VALID = 1'b1;
      bus.REQ_LANE  = 3'(lane);
      bus.REQ_OP    = 2'(op);
      bus.REQ_COUNT = 7'(cnt);
      drive_oor(lane, hi);
      @(posedge FAB_CLK); #1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_LANE  = 3'($urandom);
      bus.REQ_OP    = 2'($urandom);
      bus.REQ_COUNT = 7'($urandom);
      c = 1;
      done = 1'b0;
      while (!done && c <= 1000) begin
         sb = dl_load | dl_move;
         if ($countones(sb) > 1 || (sb & ~lm) != '0) o.bad++;
         if (bus.REQ_READY || bus.BUSY != 1'b1) o.bad++;
         if ((dl_move & lm) != '0) begin
            if (c != 2 + o.moves * (1 + S)) o.bad++;
            o.moves++;
         end
         if ((dl_load & lm) != '0) begin
            if (c != 1) o.bad++;
            o.loads++;
         end
         if (oor_k >= 0 &&
             ((op == OP_LOAD && o.loads == 1) ||
              (op != OP_LOAD && o.moves == oor_k + 1)))
            hi = 1'b1;
         if (bus.RSP_VALID) begin
            o.lat = c;
            o.tap = int'(bus.RSP_TAP);
            o.err = int'(bus.RSP_ERR);
            done  = 1'b1;
         end
         drive_oor(lane, hi);
         @(posedge FAB_CLK); #1; c++;
      end
      if (bus.RSP_VALID || !bus.REQ_READY || bus.BUSY) o.bad++;
      drive_oor(lane, 1'b0);
   endtask

   task automatic compare(input string tag, input res_t o, input res_t e);
      chk({tag, ".lat"},   o.lat,   e.lat);
      chk({tag, ".tap"},   o.tap,   e.tap);
      chk({tag, ".err"},   o.err,   e.err);
      chk({tag, ".moves"}, o.moves, e.moves);
      chk({tag, ".loads"}, o.loads, e.loads);
      chk({tag, ".rules"}, o.bad,   0);
      chk({tag, ".dir"},   int'(dl_dir), int'(m_dir));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".ready"}, int'(bus.REQ_READY), 1);
      chk({tag, ".busy"},  int'(bus.BUSY), 0);
      chk({tag, ".rspv"},  int'(bus.RSP_VALID), 0);
      chk({tag, ".load"},  int'(dl_load), 0);
      chk({tag, ".move"},  int'(dl_move), 0);
      chk({tag, ".dir"},   int'(dl_dir), 0);
   endtask

   initial begin
      #990000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [$];
      res_t o;
      res_t e;
      int   c;

      bus.REQ_VALID = 1'b0;
      bus.REQ_LANE  = '0;
      bus.REQ_OP    = '0;
      bus.REQ_COUNT = '0;
      for (int i = 0; i < NL; i++) m_tap[i] = 0;

      #23;
      chk_idle_outputs("reset");
      chk("reset.rsp_tap", int'(bus.RSP_TAP), 0);
      @(negedge FAB_CLK);
      ARST_N = 1'b1;
      @(posedge FAB_CLK); #1;

      //                lane op      cnt  oork tap err lat  mv  ld
      tbl.push_back('{3, OP_READ, 0,   -1,  0,  0,  1,   0,  0});
      tbl.push_back('{0, OP_LOAD, 0,   -1,  0,  0,  6,   0,  1});
      tbl.push_back('{0, OP_INC,  3,   -1,  3,  0,  17,  3,  0});
      tbl.push_back('{5, OP_LOAD, 0,   -1,  0,  0,  6,   0,  1});
      tbl.push_back('{5, OP_INC,  2,   -1,  2,  0,  12,  2,  0});
      tbl.push_back('{5, OP_DEC,  3,   -1,  2,  1,  1,   0,  0});
      tbl.push_back('{5, OP_INC,  126, -1,  2,  1,  1,   0,  0});
      tbl.push_back('{5, OP_INC,  125, -1,  127, 0, 627, 125, 0});
      tbl.push_back('{5, OP_INC,  1,   -1,  127, 1, 1,   0,  0});
      tbl.push_back('{5, OP_DEC,  0,   -1,  127, 0, 1,   0,  0});
      tbl.push_back('{1, OP_LOAD, 0,   -1,  0,  0,  6,   0,  1});
      tbl.push_back('{1, OP_INC,  10,  2,   3,  1,  17,  3,  0});
      tbl.push_back('{6, OP_READ, 0,   -1,  0,  1,  1,   0,  0});
      tbl.push_back('{7, OP_INC,  5,   -1,  0,  1,  1,   0,  0});
      tbl.push_back('{0, OP_DEC,  3,   -1,  0,  0,  17,  3,  0});
      tbl.push_back('{2, OP_LOAD, 0,   0,   0,  1,  6,   0,  1});
      tbl.push_back('{5, OP_READ, 0,   -1,  127, 0, 1,   0,  0});

      foreach (tbl[i]) begin
         res_t want;
         model(tbl[i].lane, tbl[i].op, tbl[i].cnt, tbl[i].oor_k, e);
         want = '{tbl[i].tap, tbl[i].err, tbl[i].lat,
                  tbl[i].moves, tbl[i].loads, 0};
         run(tbl[i].lane, tbl[i].op, tbl[i].cnt, tbl[i].oor_k, o);
         compare($sformatf("vec%0d", i), o, want);
      end

      // Reset while a MOVE strobe is on the wire.
      bus.REQ_VALID = 1'b1;
      bus.REQ_LANE  = 3'd0;
      bus.REQ_OP    = 2'(OP_INC);
      bus.REQ_COUNT = 7'd10;
      drive_oor(0, 1'b0);
      @(posedge FAB_CLK); #1;
      bus.REQ_VALID = 1'b0;
      c = 0;
      while (!dl_move[0] && c < 20) begin
         @(posedge FAB_CLK); #1; c++;
      end
      chk("rst_seq.move_seen", int'(dl_move[0]), 1);
      #2;
      ARST_N = 1'b0;
      #1;
      chk_idle_outputs("rst_seq");
      chk("rst_seq.rsp_tap", int'(bus.RSP_TAP), 0);
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      ARST_N = 1'b1;
      for (int i = 0; i < NL; i++) m_tap[i] = 0;
      m_dir = '0;
      @(posedge FAB_CLK); #1;
      model(0, OP_READ, 0, -1, e);
      run(0, OP_READ, 0, -1, o);
      compare("rst_read0", o, e);
      model(5, OP_READ, 0, -1, e);
      run(5, OP_READ, 0, -1, o);
      compare("rst_read5", o, e);

      for (int n = 0; n < 60; n++) begin
         int lane;
         int op;
         int cnt;
         int oor_k;
         int t;
         int sel;
         lane = $urandom_range(0, 7);
         op   = $urandom_range(0, 3);
         t    = (lane < NL) ? m_tap[lane] : 0;
         sel  = $urandom_range(0, 3);
         cnt  = $urandom_range(0, 6);
         if (sel == 2) begin
            cnt = (op == OP_INC) ? MT - t + 1 : t + 1;
            if (cnt > MT) cnt = MT;
         end else if (sel == 3) begin
            cnt = (op == OP_INC) ? MT - t : t;
            if (cnt > 8) cnt = $urandom_range(1, 8);
         end
         oor_k = -1;
         if ($urandom_range(0, 3) == 0)
            oor_k = (op == OP_LOAD) ? 0 : $urandom_range(0, 7);
         model(lane, op, cnt, oor_k, e);
         run(lane, op, cnt, oor_k, o);
         compare($sformatf("rnd%0d", n), o, e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
